// File: rtl/rx_controller.sv
// USB receive-side packet controller: checks SYNC/PID, streams DATA payload into the buffer, drops CRC.
// Optional macro RX_CRC_CHECK_EN: verify the two trailing CRC bytes against the TX placeholders 8'd13, 8'd14.
module rx_controller #(
  parameter int          BUF_DEPTH   = 64,
  parameter int          MAX_PAYLOAD = 64,
  parameter logic [7:0]  SYNC_BYTE   = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic [6:0] buffer_occupancy,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] rx_data,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       rx_transfer_active
);

  localparam int PW = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, EOP_WAIT, DONE, ERR_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            rcving_q, rcving_d;
  logic            w_enable_q, w_enable_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [2:0]      rx_packet_q, rx_packet_d;
  logic            rx_data_ready_q, rx_data_ready_d;
  logic            rx_error_q, rx_error_d;
  logic            rx_transfer_active_q, rx_transfer_active_d;
  logic [7:0]      h0_q, h0_d, h1_q, h1_d;
  logic [1:0]      held_q, held_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic            eop_strobe;
  logic            write_blocked;

  assign eop_strobe    = eop & shift_enable;
  assign write_blocked = (buffer_occupancy == 7'(BUF_DEPTH)) || (payload_q == PW'(MAX_PAYLOAD));

  always_comb begin
    state_d              = state_q;
    rcving_d             = rcving_q;
    w_enable_d           = 1'b0;
    rx_data_d            = rx_data_q;
    rx_packet_d          = rx_packet_q;
    rx_data_ready_d      = 1'b0;
    rx_error_d           = rx_error_q;
    rx_transfer_active_d = rx_transfer_active_q;
    h0_d                 = h0_q;
    h1_d                 = h1_q;
    held_d               = held_q;
    payload_d            = payload_q;

    case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d              = SYNC;
          rcving_d             = 1'b1;
          rx_error_d           = 1'b0;
          rx_packet_d          = 3'd0;
          rx_transfer_active_d = 1'b0;
          h0_d                 = 8'd0;
          h1_d                 = 8'd0;
          held_d               = 2'd0;
          payload_d            = '0;
        end
      end
      SYNC: begin
        if (byte_received) state_d = (rcv_data == SYNC_BYTE) ? PID : ERR_WAIT;
        else if (eop_strobe) state_d = ERR_WAIT;
      end
      PID: begin
        if (byte_received) begin
          case (rcv_data)
            8'h3C: begin
              state_d              = DATA;
              rx_packet_d          = 3'd1;
              rx_transfer_active_d = 1'b1;
            end
            8'h2D: begin state_d = EOP_WAIT; rx_packet_d = 3'd2; end
            8'hA5: begin state_d = EOP_WAIT; rx_packet_d = 3'd3; end
            8'hE1: begin state_d = EOP_WAIT; rx_packet_d = 3'd4; end
            default: state_d = ERR_WAIT;
          endcase
        end else if (eop_strobe) begin
          state_d = ERR_WAIT;
        end
      end
      DATA: begin
        // The two newest bytes are held back: they become the CRC if EOP follows.
        if (byte_received) begin
          if (held_q == 2'd2) begin
            if (write_blocked) begin
              state_d = ERR_WAIT;
            end else begin
              w_enable_d = 1'b1;
              rx_data_d  = h1_q;
              payload_d  = payload_q + 1'b1;
            end
          end
          h1_d = h0_q;
          h0_d = rcv_data;
          if (held_q != 2'd2) held_d = held_q + 2'd1;
        end else if (eop_strobe) begin
          if (held_q == 2'd2) begin
`ifdef RX_CRC_CHECK_EN
            if ({h1_q, h0_q} != {8'd13, 8'd14}) begin
              state_d              = IDLE;
              rx_error_d           = 1'b1;
              rcving_d             = 1'b0;
              rx_transfer_active_d = 1'b0;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            state_d              = IDLE;
            rx_error_d           = 1'b1;
            rcving_d             = 1'b0;
            rx_transfer_active_d = 1'b0;
          end
        end
      end
      EOP_WAIT: begin
        if (byte_received)   state_d = ERR_WAIT;
        else if (eop_strobe) state_d = DONE;
      end
      DONE: begin
        state_d              = IDLE;
        rx_data_ready_d      = 1'b1;
        rcving_d             = 1'b0;
        rx_transfer_active_d = 1'b0;
      end
      ERR_WAIT: begin
        if (eop_strobe) begin
          state_d  = IDLE;
          rcving_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flag the error on the same edge that enters the error state.
    if (state_d == ERR_WAIT) begin
      rx_error_d           = 1'b1;
      rx_transfer_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= IDLE;
      rcving_q             <= 1'b0;
      w_enable_q           <= 1'b0;
      rx_data_q            <= 8'd0;
      rx_packet_q          <= 3'd0;
      rx_data_ready_q      <= 1'b0;
      rx_error_q           <= 1'b0;
      rx_transfer_active_q <= 1'b0;
      h0_q                 <= 8'd0;
      h1_q                 <= 8'd0;
      held_q               <= 2'd0;
      payload_q            <= '0;
    end else begin
      state_q              <= state_d;
      rcving_q             <= rcving_d;
      w_enable_q           <= w_enable_d;
      rx_data_q            <= rx_data_d;
      rx_packet_q          <= rx_packet_d;
      rx_data_ready_q      <= rx_data_ready_d;
      rx_error_q           <= rx_error_d;
      rx_transfer_active_q <= rx_transfer_active_d;
      h0_q                 <= h0_d;
      h1_q                 <= h1_d;
      held_q               <= held_d;
      payload_q            <= payload_d;
    end
  end

  assign rcving             = rcving_q;
  assign w_enable           = w_enable_q;
  assign rx_data            = rx_data_q;
  assign rx_packet          = rx_packet_q;
  assign rx_data_ready      = rx_data_ready_q;
  assign rx_error           = rx_error_q;
  assign rx_transfer_active = rx_transfer_active_q;

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller: handshake, DATA payload streaming, error paths and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the DUT edge.
module tb_rx_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_edge, eop, shift_enable, byte_received;
  logic [7:0] rcv_data;
  logic [6:0] buffer_occupancy;
  logic       rcving, w_enable, rx_data_ready, rx_error, rx_transfer_active;
  logic [7:0] rx_data;
  logic [2:0] rx_packet;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int wr_cnt    = 0;
  int rdy_cnt   = 0;

  rx_controller dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .byte_received(byte_received), .rcv_data(rcv_data), .buffer_occupancy(buffer_occupancy),
    .rcving(rcving), .w_enable(w_enable), .rx_data(rx_data), .rx_packet(rx_packet),
    .rx_data_ready(rx_data_ready), .rx_error(rx_error), .rx_transfer_active(rx_transfer_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_enable)      wr_cnt  <= wr_cnt + 1;
    if (rx_data_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_d_edge();
    @(negedge clk) d_edge = 1'b1;
    @(negedge clk) d_edge = 1'b0;
  endtask

  // Returns the write strobe and data seen exactly one cycle after the byte pulse.
  task automatic send_byte(input logic [7:0] b, output logic we, output logic [7:0] wd);
    @(negedge clk) begin byte_received = 1'b1; rcv_data = b; end
    @(negedge clk) begin byte_received = 1'b0; we = w_enable; wd = rx_data; end
  endtask

  task automatic send_eop();
    @(negedge clk) begin eop = 1'b1; shift_enable = 1'b1; end
    @(negedge clk) begin eop = 1'b0; shift_enable = 1'b0; end
    idle(3);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    check_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0;
    rcv_data = 8'h00; buffer_occupancy = 7'd0;
    idle(3);
    check_cnt++; if (rcving !== 1'b0) $display("FAIL reset_rcving: got %b expected 0", rcving); else pass_cnt++;
    check_cnt++; if (w_enable !== 1'b0) $display("FAIL reset_w_enable: got %b expected 0", w_enable); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else pass_cnt++;
    check_cnt++; if (rx_packet !== 3'd0) $display("FAIL reset_rx_packet: got %0d expected 0", rx_packet); else pass_cnt++;
    check_cnt++; if (rx_data_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", rx_data_ready); else pass_cnt++;
    check_cnt++; if (rx_error !== 1'b0) $display("FAIL reset_error: got %b expected 0", rx_error); else pass_cnt++;
    check_cnt++; if (rx_transfer_active !== 1'b0) $display("FAIL reset_xfer: got %b expected 0", rx_transfer_active); else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    idle(2);
  endtask

  task automatic test_ack();
    logic we; logic [7:0] wd;
    int wr0 = wr_cnt, rdy0 = rdy_cnt;
    pulse_d_edge();
    check_cnt++; if (rcving !== 1'b1) $display("FAIL ack_rcving: got %b expected 1", rcving); else pass_cnt++;
    send_byte(8'h80, we, wd);
    send_byte(8'h2D, we, wd);
    check_cnt++; if (rx_packet !== 3'd2) $display("FAIL ack_packet: got %0d expected 2", rx_packet); else pass_cnt++;
    send_eop();
    check_cnt++; if (rdy_cnt - rdy0 !== 1) $display("FAIL ack_ready_pulses: got %0d expected 1", rdy_cnt - rdy0); else pass_cnt++;
    check_cnt++; if (wr_cnt - wr0 !== 0) $display("FAIL ack_writes: got %0d expected 0", wr_cnt - wr0); else pass_cnt++;
    check_cnt++; if (rx_error !== 1'b0) $display("FAIL ack_error: got %b expected 0", rx_error); else pass_cnt++;
    check_cnt++; if (rcving !== 1'b0) $display("FAIL ack_rcving_end: got %b expected 0", rcving); else pass_cnt++;
  endtask

  task automatic test_data();
    logic we; logic [7:0] wd;
    logic [7:0] bytes [5];
    logic       exp_we [5];
    logic [7:0] exp_wd [5];
    int wr0 = wr_cnt, rdy0 = rdy_cnt;
    bytes  = '{8'h11, 8'h22, 8'h33, 8'h0D, 8'h0E};
    exp_we = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_wd = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    pulse_d_edge();
    send_byte(8'h80, we, wd);
    send_byte(8'h3C, we, wd);
    check_cnt++; if (rx_packet !== 3'd1) $display("FAIL data_packet: got %0d expected 1", rx_packet); else pass_cnt++;
    check_cnt++; if (rx_transfer_active !== 1'b1) $display("FAIL data_xfer: got %b expected 1", rx_transfer_active); else pass_cnt++;
    pulse_d_edge();
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], we, wd);
      check_cnt++;
      if (we !== exp_we[i]) $display("FAIL data_we%0d: got %b expected %b", i, we, exp_we[i]); else pass_cnt++;
      if (exp_we[i]) check($sformatf("data_wd%0d", i), wd, exp_wd[i]);
    end
    send_eop();
    check_cnt++; if (wr_cnt - wr0 !== 3) $display("FAIL data_writes: got %0d expected 3", wr_cnt - wr0); else pass_cnt++;
    check_cnt++; if (rdy_cnt - rdy0 !== 1) $display("FAIL data_ready: got %0d expected 1", rdy_cnt - rdy0); else pass_cnt++;
    check_cnt++; if (rx_transfer_active !== 1'b0) $display("FAIL data_xfer_end: got %b expected 0", rx_transfer_active); else pass_cnt++;
    check_cnt++; if (rx_error !== 1'b0) $display("FAIL data_error: got %b expected 0", rx_error); else pass_cnt++;
  endtask

  task automatic test_bad_sync();
    logic we; logic [7:0] wd;
    int wr0 = wr_cnt, rdy0 = rdy_cnt;
    pulse_d_edge();
    send_byte(8'h81, we, wd);
    send_byte(8'h3C, we, wd);
    send_eop();
    check_cnt++; if (rx_error !== 1'b1) $display("FAIL badsync_error: got %b expected 1", rx_error); else pass_cnt++;
    check_cnt++; if (wr_cnt - wr0 !== 0) $display("FAIL badsync_writes: got %0d expected 0", wr_cnt - wr0); else pass_cnt++;
    check_cnt++; if (rdy_cnt - rdy0 !== 0) $display("FAIL badsync_ready: got %0d expected 0", rdy_cnt - rdy0); else pass_cnt++;
    check_cnt++; if (rcving !== 1'b0) $display("FAIL badsync_rcving: got %b expected 0", rcving); else pass_cnt++;
    pulse_d_edge();
    check_cnt++; if (rx_error !== 1'b0) $display("FAIL badsync_clear: got %b expected 0", rx_error); else pass_cnt++;
    send_byte(8'h80, we, wd);
    send_byte(8'hA5, we, wd);
    check_cnt++; if (rx_packet !== 3'd3) $display("FAIL nak_packet: got %0d expected 3", rx_packet); else pass_cnt++;
    send_eop();
    check_cnt++; if (rdy_cnt - rdy0 !== 1) $display("FAIL nak_ready: got %0d expected 1", rdy_cnt - rdy0); else pass_cnt++;
  endtask

  task automatic test_buffer_full();
    logic we; logic [7:0] wd;
    int wr0 = wr_cnt, rdy0 = rdy_cnt;
    buffer_occupancy = 7'd64;
    pulse_d_edge();
    send_byte(8'h80, we, wd);
    send_byte(8'h3C, we, wd);
    send_byte(8'hAA, we, wd);
    send_byte(8'hBB, we, wd);
    send_byte(8'hCC, we, wd);
    check_cnt++; if (we !== 1'b0) $display("FAIL full_we: got %b expected 0", we); else pass_cnt++;
    check_cnt++; if (rx_error !== 1'b1) $display("FAIL full_error: got %b expected 1", rx_error); else pass_cnt++;
    check_cnt++; if (rx_transfer_active !== 1'b0) $display("FAIL full_xfer: got %b expected 0", rx_transfer_active); else pass_cnt++;
    send_eop();
    check_cnt++; if (rcving !== 1'b0) $display("FAIL full_rcving: got %b expected 0", rcving); else pass_cnt++;
    check_cnt++; if (wr_cnt - wr0 !== 0) $display("FAIL full_writes: got %0d expected 0", wr_cnt - wr0); else pass_cnt++;
    check_cnt++; if (rdy_cnt - rdy0 !== 0) $display("FAIL full_ready: got %0d expected 0", rdy_cnt - rdy0); else pass_cnt++;
    buffer_occupancy = 7'd0;
  endtask

  task automatic test_short_and_zero_payload();
    logic we; logic [7:0] wd;
    int wr0 = wr_cnt, rdy0 = rdy_cnt;
    pulse_d_edge();
    send_byte(8'h80, we, wd);
    send_byte(8'h3C, we, wd);
    send_byte(8'h55, we, wd);
    send_eop();
    check_cnt++; if (rx_error !== 1'b1) $display("FAIL short_error: got %b expected 1", rx_error); else pass_cnt++;
    check_cnt++; if (rcving !== 1'b0) $display("FAIL short_rcving: got %b expected 0", rcving); else pass_cnt++;
    check_cnt++; if (rdy_cnt - rdy0 !== 0) $display("FAIL short_ready: got %0d expected 0", rdy_cnt - rdy0); else pass_cnt++;
    pulse_d_edge();
    send_byte(8'h80, we, wd);
    send_byte(8'h3C, we, wd);
    send_byte(8'h0D, we, wd);
    send_byte(8'h0E, we, wd);
    send_eop();
    check_cnt++; if (rdy_cnt - rdy0 !== 1) $display("FAIL zero_ready: got %0d expected 1", rdy_cnt - rdy0); else pass_cnt++;
    check_cnt++; if (wr_cnt - wr0 !== 0) $display("FAIL zero_writes: got %0d expected 0", wr_cnt - wr0); else pass_cnt++;
    check_cnt++; if (rx_error !== 1'b0) $display("FAIL zero_error: got %b expected 0", rx_error); else pass_cnt++;
  endtask

  task automatic test_stall_extra_byte();
    logic we; logic [7:0] wd;
    int rdy0 = rdy_cnt;
    pulse_d_edge();
    send_byte(8'h80, we, wd);
    send_byte(8'hE1, we, wd);
    send_byte(8'h99, we, wd);
    check_cnt++; if (rx_error !== 1'b1) $display("FAIL stall_extra_error: got %b expected 1", rx_error); else pass_cnt++;
    send_eop();
    check_cnt++; if (rx_packet !== 3'd4) $display("FAIL stall_packet: got %0d expected 4", rx_packet); else pass_cnt++;
    check_cnt++; if (rdy_cnt - rdy0 !== 0) $display("FAIL stall_ready: got %0d expected 0", rdy_cnt - rdy0); else pass_cnt++;
  endtask

`ifdef RX_CRC_CHECK_EN
  task automatic test_crc_check();
    logic we; logic [7:0] wd;
    int rdy0 = rdy_cnt;
    pulse_d_edge();
    send_byte(8'h80, we, wd); send_byte(8'h3C, we, wd); send_byte(8'h55, we, wd);
    send_byte(8'h0D, we, wd); send_byte(8'h0F, we, wd);
    send_eop();
    check_cnt++; if (rx_error !== 1'b1) $display("FAIL crc_bad_error: got %b expected 1", rx_error); else pass_cnt++;
    check_cnt++; if (rdy_cnt - rdy0 !== 0) $display("FAIL crc_bad_ready: got %0d expected 0", rdy_cnt - rdy0); else pass_cnt++;
    pulse_d_edge();
    send_byte(8'h80, we, wd); send_byte(8'h3C, we, wd); send_byte(8'h55, we, wd);
    send_byte(8'h0D, we, wd); send_byte(8'h0E, we, wd);
    send_eop();
    check_cnt++; if (rdy_cnt - rdy0 !== 1) $display("FAIL crc_good_ready: got %0d expected 1", rdy_cnt - rdy0); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_packet();
    logic we; logic [7:0] wd;
    int rdy0;
    pulse_d_edge();
    send_byte(8'h80, we, wd);
    send_byte(8'h3C, we, wd);
    @(negedge clk) rst = 1'b1;
    #1;
    check_cnt++; if (rcving !== 1'b0) $display("FAIL midrst_rcving: got %b expected 0", rcving); else pass_cnt++;
    check_cnt++; if (rx_packet !== 3'd0) $display("FAIL midrst_packet: got %0d expected 0", rx_packet); else pass_cnt++;
    check_cnt++; if (rx_transfer_active !== 1'b0) $display("FAIL midrst_xfer: got %b expected 0", rx_transfer_active); else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    idle(1);
    rdy0 = rdy_cnt;
    pulse_d_edge();
    send_byte(8'h80, we, wd);
    send_byte(8'h2D, we, wd);
    send_eop();
    check_cnt++; if (rx_packet !== 3'd2) $display("FAIL midrst_next_packet: got %0d expected 2", rx_packet); else pass_cnt++;
    check_cnt++; if (rdy_cnt - rdy0 !== 1) $display("FAIL midrst_next_ready: got %0d expected 1", rdy_cnt - rdy0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data();
    test_bad_sync();
    test_buffer_full();
    test_short_and_zero_payload();
    test_stall_extra_byte();
`ifdef RX_CRC_CHECK_EN
    test_crc_check();
`endif
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
